// File: rtl/btn_pulse_gen.sv
// Multi-channel button conditioner: synchronise, debounce, then emit press/release
// strobes and optional auto-repeat pulses. All outputs come straight from flops.
module btn_pulse_gen #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_rpt,
  output logic [N-1:0] btn_act
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_MAX      = DB_W'(DB_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP    = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic              IDLE_RAW    = (ACTIVE_LOW != 0);
  localparam logic              RPT_ON      = (REPEAT_EN != 0);

  typedef enum logic [1:0] {IDLE, HOLD_DELAY, REPEATING} rpt_state_t;

  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
    return (v == DB_MAX) ? v : v + DB_W'(1);
  endfunction

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_TOP) ? v : v + HOLD_W'(1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic              s1, s2;
    logic              pressed;
    logic              mismatch, accept, rise, fall;
    logic [DB_W-1:0]   db_cnt;
    logic              level_q, press_q, release_q, rpt_q, act_q;
    rpt_state_t        state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic              rpt_nx;

    // The synchroniser carries raw polarity so its reset value is the idle level;
    // the ACTIVE_LOW inversion is applied on its output.
    assign pressed  = s2 ^ IDLE_RAW;
    assign mismatch = (pressed != level_q);
    assign accept   = mismatch && (db_cnt == DB_LAST);
    assign rise     = accept && !level_q;
    assign fall     = accept && level_q;

    always_comb begin
      state_nx = state;
      hold_nx  = '0;
      rpt_nx   = 1'b0;
      case (state)
        IDLE: begin
          if (rise && RPT_ON) state_nx = HOLD_DELAY;
        end
        HOLD_DELAY: begin
          if (fall) begin
            state_nx = IDLE;
          end else if (hold_cnt == DELAY_LAST) begin
            rpt_nx   = 1'b1;
            state_nx = REPEATING;
          end else begin
            hold_nx = hold_inc(hold_cnt);
          end
        end
        REPEATING: begin
          // A release landing on a repeat instant suppresses that repeat.
          if (fall) begin
            state_nx = IDLE;
          end else if (hold_cnt == PERIOD_LAST) begin
            rpt_nx = 1'b1;
          end else begin
            hold_nx = hold_inc(hold_cnt);
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1        <= IDLE_RAW;
        s2        <= IDLE_RAW;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_q     <= 1'b0;
        act_q     <= 1'b0;
        state     <= IDLE;
        hold_cnt  <= '0;
      end else begin
        s1        <= btn_raw[g];
        s2        <= s1;
        db_cnt    <= (mismatch && !accept) ? db_inc(db_cnt) : '0;
        level_q   <= accept ? !level_q : level_q;
        press_q   <= rise;
        release_q <= fall;
        rpt_q     <= rpt_nx;
        act_q     <= rise | rpt_nx;
        state     <= state_nx;
        hold_cnt  <= hold_nx;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_rpt[g]     = rpt_q;
    assign btn_act[g]     = act_q;
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: two instances (active-high with repeat, active-low without)
// driven with directed and random bouncing inputs, checked by a per-cycle scoreboard.
module tb_btn_pulse_gen;
  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] raw_a, raw_b;
  logic [N-1:0] lvl_a, prs_a, rel_a, rpt_a, act_a;
  logic [N-1:0] lvl_b, prs_b, rel_b, rpt_b, act_b;

  btn_pulse_gen #(.N(N), .DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
                  .REPEAT_PERIOD(RP), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .btn_raw(raw_a), .btn_level(lvl_a), .btn_press(prs_a),
    .btn_release(rel_a), .btn_rpt(rpt_a), .btn_act(act_a));

  btn_pulse_gen #(.N(N), .DB_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
                  .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(raw_b), .btn_level(lvl_b), .btn_press(prs_b),
    .btn_release(rel_b), .btn_rpt(rpt_b), .btn_act(act_b));

  typedef struct packed {
    int          edge_no;
    logic [19:0] a;
    logic [19:0] b;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model history, indexed by clock-edge number.
  logic       rst_h [MAXC];
  logic [3:0] pr_h  [2][MAXC];
  logic [3:0] ys    [2][MAXC];
  logic [3:0] lv    [2][MAXC];
  int         tp    [2][4];
  int         k = 0;

  // Level flips once the last DB synchronised samples all disagree with it; repeats
  // fall at press+RD, press+RD+RP, ... while the level is still held.
  function automatic logic [19:0] model(input int i, input logic in_rst, input logic [3:0] raw);
    logic [3:0] y, lprev, lnew, prs, rel, rpt, act;
    logic       all_diff;
    int         idx, dt;
    pr_h[i][k] = (i == 1) ? ~raw : raw;
    if (in_rst || k < 2) y = '0;
    else if (rst_h[k-1] || rst_h[k-2]) y = '0;
    else y = pr_h[i][k-2];
    ys[i][k] = y;
    lprev = (k == 0) ? 4'h0 : lv[i][k-1];
    lnew = '0; prs = '0; rel = '0; rpt = '0; act = '0;
    for (int c = 0; c < 4; c++) begin
      if (!in_rst) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          idx = k - j;
          if (idx < 0) all_diff = 1'b0;
          else if (ys[i][idx][c] == lprev[c]) all_diff = 1'b0;
        end
        lnew[c] = all_diff ? ~lprev[c] : lprev[c];
        prs[c]  = lnew[c] & ~lprev[c];
        rel[c]  = ~lnew[c] & lprev[c];
        if (prs[c]) tp[i][c] = k;
        dt = k - tp[i][c];
        rpt[c] = (i == 0) && lnew[c] && !prs[c] && (dt >= RD) && (((dt - RD) % RP) == 0);
        act[c] = prs[c] | rpt[c];
      end
    end
    lv[i][k] = lnew;
    return {lnew, prs, rel, rpt, act};
  endfunction

  task automatic step(input logic rst_pin, input logic [3:0] ra, input logic [3:0] rb);
    exp_t e;
    @(negedge clk);
    rst   = rst_pin;
    raw_a = ra;
    raw_b = rb;
    if (k < MAXC) begin
      rst_h[k]  = !rst_pin;
      e.edge_no = k;
      e.a       = model(0, !rst_pin, ra);
      e.b       = model(1, !rst_pin, rb);
      sbq.push_back(e);
      k++;
    end
  endtask

  task automatic hold(input int n, input logic rst_pin, input logic [3:0] ra, input logic [3:0] rb);
    for (int i = 0; i < n; i++) step(rst_pin, ra, rb);
  endtask

  // Monitor: every output is valid each cycle, so one entry is consumed per edge.
  initial begin
    exp_t        e;
    logic [19:0] got_a, got_b;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e     = sbq.pop_front();
        got_a = {lvl_a, prs_a, rel_a, rpt_a, act_a};
        got_b = {lvl_b, prs_b, rel_b, rpt_b, act_b};
        n_cmp++;
        if (got_a !== e.a) begin
          n_bad++;
          $display("FAIL dut_a edge %0d: got lvl/prs/rel/rpt/act=%h, expected %h", e.edge_no, got_a, e.a);
        end
        n_cmp++;
        if (got_b !== e.b) begin
          n_bad++;
          $display("FAIL dut_b edge %0d: got lvl/prs/rel/rpt/act=%h, expected %h", e.edge_no, got_b, e.b);
        end
      end
    end
  end

  initial begin
    logic [3:0] ra, rb;
    int         p;
    rst   = 1'b0;
    raw_a = 4'hF;
    raw_b = 4'hF;
    // Reset with all A buttons held: press on all four after release of reset.
    hold(3, 1'b0, 4'hF, 4'hF);
    hold(12, 1'b1, 4'hF, 4'hF);
    hold(12, 1'b1, 4'h0, 4'hF);
    // Short glitch on channel 0 must be rejected.
    hold(3, 1'b1, 4'h1, 4'hF);
    hold(10, 1'b1, 4'h0, 4'hF);
    // Long hold on channel 0 with auto-repeat, then release.
    hold(40, 1'b1, 4'h1, 4'hF);
    hold(15, 1'b1, 4'h0, 4'hF);
    // Channels 1 and 3 together.
    hold(12, 1'b1, 4'hA, 4'hF);
    hold(10, 1'b1, 4'h0, 4'hF);
    // Channel 2 repeating, reset mid-hold, then re-accepted after reset.
    hold(25, 1'b1, 4'h4, 4'hF);
    hold(2, 1'b0, 4'h4, 4'hF);
    hold(12, 1'b1, 4'h4, 4'hF);
    hold(8, 1'b1, 4'h0, 4'hF);
    // Active-low instance: channel 2 pressed, no repeats expected.
    hold(20, 1'b1, 4'h0, 4'hB);
    hold(10, 1'b1, 4'h0, 4'hF);
    // Random bouncing with varying flip rates and occasional resets.
    ra = 4'h0;
    rb = 4'hF;
    for (int seg = 0; seg < 15; seg++) begin
      case (seg % 3)
        0: p = 3;
        1: p = 8;
        default: p = 25;
      endcase
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(p - 1) == 0) ra[c] = ~ra[c];
          if ($urandom_range(p - 1) == 0) rb[c] = ~rb[c];
        end
        step(($urandom_range(199) == 0) ? 1'b0 : 1'b1, ra, rb);
      end
    end
    hold(20, 1'b1, 4'h0, 4'hF);
    @(posedge clk);
    #2;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
